// File: rtl/fp_divider.sv
// Single-precision divider: restoring mantissa division, one quotient bit per clock.
// Truncating, denormals flushed to zero, fixed 26-cycle latency for every operand class.
module fp_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        dz
);

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    state_t      state_q;
    logic [24:0] rem_q;
    logic [24:0] q_q;
    logic [23:0] mb_q;
    logic [7:0]  ea_q;
    logic [7:0]  eb_q;
    logic        sign_q;
    logic        za_q;
    logic        zb_q;
    logic [4:0]  cnt_q;
    logic [31:0] out_q;
    logic        busy_q;
    logic        done_q;
    logic        dz_q;

    logic        ge;
    logic [24:0] diff;
    logic [24:0] rem_d;
    logic [24:0] q_d;
    logic [9:0]  exp_d;
    logic [22:0] mant_d;
    logic [31:0] res_d;
    logic        res_dz_d;

    // Remainder stays below 2*Mb, so the shifted value fits in 25 bits.
    assign ge    = rem_q >= {1'b0, mb_q};
    assign diff  = rem_q - {1'b0, mb_q};
    assign rem_d = ge ? {diff[23:0], 1'b0} : {rem_q[23:0], 1'b0};
    assign q_d   = {q_q[23:0], ge};

    assign exp_d  = {2'b00, ea_q} - {2'b00, eb_q}
                  + (q_q[24] ? 10'd127 : 10'd126);
    assign mant_d = q_q[24] ? q_q[23:1] : q_q[22:0];

    always_comb begin
        res_d    = {sign_q, exp_d[7:0], mant_d};
        res_dz_d = 1'b0;
        if (za_q) begin
            res_d = 32'h0;
        end else if (zb_q) begin
            res_d    = {sign_q, 8'hFF, 23'h0};
            res_dz_d = 1'b1;
        end else if ($signed(exp_d) <= 10'sd0) begin
            res_d = 32'h0;
        end else if ($signed(exp_d) >= 10'sd255) begin
            res_d = {sign_q, 8'hFF, 23'h0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            mb_q    <= '0;
            ea_q    <= '0;
            eb_q    <= '0;
            sign_q  <= 1'b0;
            za_q    <= 1'b0;
            zb_q    <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= DIV;
                        busy_q  <= 1'b1;
                        rem_q   <= {2'b01, A[22:0]};
                        mb_q    <= {1'b1, B[22:0]};
                        q_q     <= '0;
                        cnt_q   <= '0;
                        ea_q    <= A[30:23];
                        eb_q    <= B[30:23];
                        sign_q  <= A[31] ^ B[31];
                        za_q    <= (A[30:23] == 8'h00);
                        zb_q    <= (B[30:23] == 8'h00);
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd24) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    out_q   <= res_d;
                    dz_q    <= res_dz_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: random and directed operands against
// an integer-division reference, with latency, busy and reset checks.
module tb_fp_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        dz;

    int cyc;
    int total;
    int fails;
    logic [31:0] held_out;
    logic        held_dz;

    typedef struct {
        int          cyc;
        logic [31:0] out;
        logic        dz;
    } exp_t;

    exp_t sb[$];

    fp_divider dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .A    (A),
        .B    (B),
        .out  (out),
        .busy (busy),
        .done (done),
        .dz   (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: quotient by plain integer division, then the
    // normalisation and exception priority rules.
    function automatic exp_t model(input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t r;
        longint unsigned ma;
        longint unsigned mb;
        longint unsigned q;
        logic [22:0] m;
        logic s;
        int e;
        s  = a[31] ^ b[31];
        ma = 64'h800000 | {41'h0, a[22:0]};
        mb = 64'h800000 | {41'h0, b[22:0]};
        q  = (ma << 24) / mb;
        if (q >= 64'h1000000) begin
            m = q[23:1];
            e = int'(a[30:23]) - int'(b[30:23]) + 127;
        end else begin
            m = q[22:0];
            e = int'(a[30:23]) - int'(b[30:23]) + 126;
        end
        r.cyc = 0;
        r.dz  = 1'b0;
        if (a[30:23] == 8'h00) r.out = 32'h0;
        else if (b[30:23] == 8'h00) begin
            r.out = {s, 8'hFF, 23'h0};
            r.dz  = 1'b1;
        end
        else if (e <= 0) r.out = 32'h0;
        else if (e >= 255) r.out = {s, 8'hFF, 23'h0};
        else r.out = {s, e[7:0], m};
        return r;
    endfunction

    // Monitor: pops the scoreboard on every done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    fails++;
                    $display("FAIL spurious_done: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("out", out, e.out);
                    chk("dz", {31'h0, dz}, {31'h0, e.dz});
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                total++;
                fails++;
                $display("FAIL missing_done: got none expected at cycle %0d", sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    // Called at a negedge; start is sampled on the following posedge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input bit mid_start);
        int k;
        exp_t e;
        start = 1'b1;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        k = cyc;
        e = model(a, b);
        e.cyc = k + 26;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        chk("busy_after_start", {31'h0, busy}, 32'h1);
        chk("out_held", out, held_out);
        chk("dz_held", {31'h0, dz}, {31'h0, held_dz});
        if (mid_start) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (cyc < k + 25) @(negedge clk);
        chk("busy_last_div", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("busy_at_done", {31'h0, busy}, 32'h0);
        held_out = e.out;
        held_dz  = e.dz;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int r;
        v = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0) v[30:23] = 8'h00;
        else if (r == 1) v[30:23] = 8'hFF;
        else if (r == 2) v[30:23] = 8'($urandom_range(1, 254));
        else v[30:23] = 8'($urandom_range(60, 190));
        return v;
    endfunction

    initial begin
        int k;
        total    = 0;
        fails    = 0;
        held_out = 32'h0;
        held_dz  = 1'b0;
        rst_n    = 1'b1;
        start    = 1'b0;
        A        = 32'h0;
        B        = 32'h0;
        #3 rst_n = 1'b0;
        #1;
        chk("reset_out", out, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_done", {31'h0, done}, 32'h0);
        chk("reset_dz", {31'h0, dz}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h40C00000, 32'h40000000, 1'b1);
        run_op(32'h3F800000, 32'h40400000, 1'b0);
        run_op(32'hC0F00000, 32'h40200000, 1'b1);
        run_op(32'h40A00000, 32'h00000000, 1'b0);
        run_op(32'h00000000, 32'h00000000, 1'b0);
        run_op(32'h7F000000, 32'h3E800000, 1'b0);
        repeat (3) @(negedge clk);
        run_op(32'h00800000, 32'h40000000, 1'b0);
        run_op(32'hC0C00000, 32'h40000000, 1'b0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 4)) @(negedge clk);
            run_op(rand_fp(), rand_fp(), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a division.
        start = 1'b1;
        A = 32'h41200000;
        B = 32'h40000000;
        @(posedge clk);
        #1;
        k = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < k + 10) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_out", out, 32'h0);
        chk("midreset_busy", {31'h0, busy}, 32'h0);
        chk("midreset_done", {31'h0, done}, 32'h0);
        chk("midreset_dz", {31'h0, dz}, 32'h0);
        held_out = 32'h0;
        held_dz  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h40C00000, 32'h40000000, 1'b0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, the only clock.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  request to begin a division; sampled on rising clk.
REQ-004 SHALL have port: A  input  32  IEEE-754 single-precision dividend, sampled with start.
REQ-005 SHALL have port: B  input  32  IEEE-754 single-precision divisor, sampled with start.
REQ-006 SHALL have port: out  output  32  registered quotient A/B; holds its value until the next completion.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse marking an updated out.
REQ-009 SHALL have port: dz  output  1  divide-by-zero flag, updated together with out.

Function
REQ-010 SHALL use FSM states IDLE, DIV and NORM: IDLE->DIV on start; DIV->NORM after 25 iterations; NORM->IDLE always.
REQ-011 SHALL accept start only in IDLE; start during DIV or NORM is ignored and operands are not re-sampled.
REQ-012 SHALL latch A and B on the accepting edge k and set busy=1 from that edge.
REQ-013 SHALL compute sign = A[31] ^ B[31].
REQ-014 SHALL treat any operand with exponent field 0 as zero; denormals are flushed.
REQ-015 SHALL not special-case NaN or Inf; exponent 255 is handled as an ordinary value.
REQ-016 SHALL form Ma={1,A[22:0]} and Mb={1,B[22:0]}.
REQ-017 SHALL derive 25 quotient bits Q = floor((Ma<<24)/Mb) by restoring division, one bit per clock, MSB first, on edges k+1..k+25.
REQ-018 SHALL use a 25-bit partial remainder, or wider, so that no iteration overflows.
REQ-019 SHALL normalise in NORM as follows.
- If Q[24]=1: mantissa = Q[23:1], E = e1 - e2 + 127.
- Otherwise: mantissa = Q[22:0], E = e1 - e2 + 126.
REQ-020 SHALL truncate the mantissa; no rounding is performed.
REQ-021 SHALL evaluate E as a signed value at least 10 bits wide.
REQ-022 SHALL select the result in NORM by this priority.
- A zero: out = 0x00000000, dz = 0.
- B zero: out = {sign, 8'hFF, 23'h0}, dz = 1.
- E <= 0: out = 0x00000000, dz = 0.
- E >= 255: out = {sign, 8'hFF, 23'h0}, dz = 0.
- Otherwise: out = {sign, E[7:0], mantissa}, dz = 0.
REQ-023 SHALL keep latency fixed for every operand class, zero and exception cases included.
- out and dz are written at edge k+26, and done=1 for the cycle that follows.
- busy=0 from edge k+26.
REQ-024 SHALL accept a new start while done is high; done falls at that edge, and out and dz hold until edge k'+26.
REQ-025 SHALL hold done low in every cycle other than the cycle following a NORM edge.

Reset
REQ-026 SHALL, on rst_n=0 and without waiting for clk, force IDLE and clear out, busy, done, dz and all datapath registers to 0.
REQ-027 SHALL abort any division in progress on reset, with no done pulse for it afterwards.
REQ-028 SHALL accept a start on the first rising clk after rst_n deasserts.

Verification
REQ-029 SHALL cover 6.0/2.0: A=0x40C00000, B=0x40000000 -> out=0x40400000, dz=0, done exactly 26 edges after the start edge, busy high for 26 cycles.
REQ-030 SHALL cover truncation and sign.
- A=0x3F800000, B=0x40400000 -> out=0x3EAAAAAA.
- A=0xC0F00000, B=0x40200000 -> out=0xC0400000.
REQ-031 SHALL cover zero operands.
- A=0x40A00000, B=0x00000000 -> out=0x7F800000, dz=1.
- A=0x00000000, B=0x00000000 -> out=0x00000000, dz=0.
REQ-032 SHALL cover range limits.
- A=0x7F000000, B=0x3E800000 -> out=0x7F800000, dz=0.
- A=0x00800000, B=0x40000000 -> out=0x00000000.
REQ-033 SHALL cover handshake rules.
- Start pulsed mid-DIV with new operands -> ignored; the first result is unchanged.
- Start coincident with the done cycle -> accepted; the second result appears 26 edges later.
REQ-034 SHALL cover reset mid-operation: rst_n low at edge k+10 -> out, busy, done and dz go to 0 immediately, and no done pulse follows.
